// File: rtl/round_sequencer_if.sv
// Grader request/acknowledge bundle between the round sequencer (master) and
// the shared Grader datapath (slave).
interface round_sequencer_if;
    // Handshake: the master raises grade_req and holds it, with grade_guess
    // stable, until the slave pulses grade_ack for one cycle; grade_znarly and
    // grade_zood are valid only in that ack cycle.
    logic        grade_req;
    logic [11:0] grade_guess;
    logic        grade_ack;
    logic [3:0]  grade_znarly;
    logic [3:0]  grade_zood;

    modport master (
        output grade_req,
        output grade_guess,
        input  grade_ack,
        input  grade_znarly,
        input  grade_zood
    );

    modport slave (
        input  grade_req,
        input  grade_guess,
        output grade_ack,
        output grade_znarly,
        output grade_zood
    );
endinterface

// File: rtl/round_sequencer.sv
// Sequences one game of guesses through the shared grader: edge-detects GradeIt,
// requests a grade, captures the result and declares the game won or lost.
module round_sequencer #(
    parameter int MAX_ROUNDS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     StartGame,
    input  logic                     Abort,
    input  logic                     GradeIt,
    input  logic [11:0]              Guess,
    round_sequencer_if.master        grader,
    output logic [3:0]               Znarly,
    output logic [3:0]               Zood,
    output logic [3:0]               RoundNumber,
    output logic                     loadZnarlyZood,
    output logic                     GameFinished,
    output logic                     GameWon,
    output logic                     busy,
    output logic [2:0]               dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_GUESS = 3'd1,
        GRADING    = 3'd2,
        UPDATE     = 3'd3,
        DONE       = 3'd4
    } state_e;

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    state_e      state_q, state_d;
    logic        gradeit_q;
    logic [11:0] guess_q, guess_d;
    logic [3:0]  znarly_q, znarly_d;
    logic [3:0]  zood_q, zood_d;
    logic [3:0]  round_q, round_d;
    logic        won_q, won_d;
    logic        rise;
    logic        win;
    logic        game_end;

    assign rise     = GradeIt & ~gradeit_q;
    // Only an exact 4 wins; out-of-range grader values are kept but never win.
    assign win      = (znarly_q == 4'd4);
    assign game_end = win || (round_q == MAX_R);

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        znarly_d = znarly_q;
        zood_d   = zood_q;
        round_d  = round_q;
        won_d    = won_q;

        case (state_q)
            IDLE, DONE: begin
                if (StartGame) begin
                    state_d  = WAIT_GUESS;
                    znarly_d = 4'd0;
                    zood_d   = 4'd0;
                    round_d  = 4'd0;
                    won_d    = 1'b0;
                end
            end
            WAIT_GUESS: begin
                if (rise) begin
                    guess_d = Guess;
                    state_d = GRADING;
                end
            end
            GRADING: begin
                if (grader.grade_ack) begin
                    znarly_d = grader.grade_znarly;
                    zood_d   = grader.grade_zood;
                    round_d  = round_q + 4'd1;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                if (win) begin
                    won_d = 1'b1;
                end
                state_d = game_end ? DONE : WAIT_GUESS;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything else in the same cycle.
        if (Abort) begin
            state_d  = IDLE;
            guess_d  = 12'd0;
            znarly_d = 4'd0;
            zood_d   = 4'd0;
            round_d  = 4'd0;
            won_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gradeit_q <= 1'b0;
            guess_q   <= 12'd0;
            znarly_q  <= 4'd0;
            zood_q    <= 4'd0;
            round_q   <= 4'd0;
            won_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gradeit_q <= GradeIt;
            guess_q   <= guess_d;
            znarly_q  <= znarly_d;
            zood_q    <= zood_d;
            round_q   <= round_d;
            won_q     <= won_d;
        end
    end

    // Outputs decode registered state only, so reset drops grade_req at once.
    assign grader.grade_req   = (state_q == GRADING);
    assign grader.grade_guess = guess_q;
    assign Znarly             = znarly_q;
    assign Zood               = zood_q;
    assign RoundNumber        = round_q;
    assign GameWon            = won_q;
    assign loadZnarlyZood     = (state_q == UPDATE);
    assign GameFinished       = (state_q == UPDATE) && game_end;
    assign busy               = (state_q == GRADING) || (state_q == UPDATE);
    assign dbg_state_o        = state_q;

endmodule
